demux1to4_stream: RTL and testbench
===================================

# demux1to4_stream

Registered 1-to-4 stream demultiplexer with valid/ready handshaking. It routes each accepted input word to one of four output channels, or to all four in broadcast mode. Each channel holds the word in its own one-entry output register. It sits on the datapath wherever one producer (register-file read port, ALU result bus) feeds four selectable consumers, and it is the distributing counterpart of the 4-to-1 select mux.

## Interface
- SIZE, 16, data width of input and each output channel
- CNT_W, 8, width of each per-channel transfer counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts the input word this cycle
- in_data  input  SIZE  input word
- in_sel  input  2  destination channel (00→ch0 … 11→ch3); ignored when in_bcast=1
- in_bcast  input  1  deliver the word to all four channels
- out_valid  output  4  per-channel word present (bit i = channel i)
- out_ready  input  4  per-channel consumer accepts
- out_data0..out_data3  output  SIZE each  channel data
- xfer_cnt0..xfer_cnt3  output  CNT_W each  saturating count of words delivered (consumed) per channel
- cnt_clr  input  1  synchronous clear of all four counters

## Operation
- Input handshake fires when in_valid && in_ready. Output handshake i fires when out_valid[i] && out_ready[i].
- A channel slot is free when it is empty (!out_valid[i]), or when it is full and draining this cycle (out_ready[i]=1).
- Unicast (in_bcast=0): in_ready = slot[in_sel] free. On fire, slot[in_sel] loads in_data and sets out_valid[in_sel]. Other slots are untouched.
- Broadcast (in_bcast=1): in_ready = all four slots free. On fire, all slots load in_data and all out_valid bits set. Partial broadcast is never performed.
- in_ready is combinational from in_sel, in_bcast, out_valid and out_ready. It does not depend on in_valid.
- Simultaneous load and drain on one slot: the slot loads the new word and out_valid stays 1. No bubble.
- Drain without load: out_valid[i] clears next cycle. out_data[i] holds its last value; a consumer must not sample it while out_valid[i]=0.
- A full slot holds out_data[i] stable until its handshake fires. A stalled channel blocks only words aimed at it (and broadcasts); other channels keep flowing.
- Counters: xfer_cnt[i] increments on each output handshake i and saturates at 2^CNT_W−1.
  - cnt_clr=1 forces all counters to 0 that cycle, overriding a same-cycle increment.

## Timing
- Latency: one cycle. A word accepted at edge N is visible on out_data at edge N+1 with out_valid set.
- Throughput: one word per cycle per channel under continuous out_ready.
- Reset: out_valid=4'b0000, all out_data = 0, all xfer_cnt = 0. in_ready is consequently 1 during and after reset.
- Reset asserted mid-operation drops all held words with no handshake. Counters do not count dropped words.
- in_sel and in_bcast are sampled only on the input-fire edge. Changes while in_valid=0 have no effect.

## Structure
- Shared constants include (with other datapath widths): default SIZE=16, CNT_W=8, channel-select encodings CH0..CH3.
- One sub-module, demux_slot: a single-entry register stage with load, drain, valid, data and saturating counter. Instantiated four times.
- Top level holds select decode, broadcast gating and in_ready logic only.

## Test plan
- Unicast sweep: after reset, send 0x1111, 0x2222, 0x3333, 0x4444 with sel 0..3 and all out_ready=1 → each appears on its channel one cycle later; each xfer_cnt reaches 1.
- Back-pressure: out_ready[2]=0; send 0xAAAA then 0xBBBB to ch2 → first held stable; in_ready=0 for the second; ch0 word 0x0C0C still passes; raising out_ready[2] delivers 0xBBBB next cycle.
- Full-rate same-slot load+drain: 10 consecutive words to ch1 with out_ready[1]=1 → out_valid[1] stays high with no bubble, data in order, xfer_cnt1=10.
- Broadcast: ch3 held full with out_ready[3]=0, send 0x5A5A with in_bcast=1 → in_ready=0 and no channel changes. Release ch3 → all four show 0x5A5A next cycle.
- Counter saturation/clear: with CNT_W=4, deliver 20 words to ch0 → xfer_cnt0=15. cnt_clr during an active handshake → 0.
- Async reset mid-stream: assert rst_n=0 between edges with all slots full → out_valid=0 and counters=0 immediately. First word after release has 1-cycle latency.

Source files
------------

// File: rtl/demux1to4_stream_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer datapath.
package demux1to4_stream_pkg;

  // Default datapath widths.
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned NUM_CH      = 4;

  // Destination channel encodings carried on in_sel.
  typedef enum logic [1:0] {
    CH0 = 2'b00,
    CH1 = 2'b01,
    CH2 = 2'b10,
    CH3 = 2'b11
  } ch_sel_e;

  // One-hot channel mask for a given select encoding.
  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_sel_e sel);
    logic [NUM_CH-1:0] mask;
    mask = '0;
    unique case (sel)
      CH0: mask = 4'b0001;
      CH1: mask = 4'b0010;
      CH2: mask = 4'b0100;
      CH3: mask = 4'b1000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/demux1to4_stream_slot.sv
// Single-entry output register stage: holds one word until its consumer
// accepts it, and counts delivered words with saturation.
module demux_slot
  import demux1to4_stream_pkg::*;
#(
  parameter int unsigned SIZE  = DATA_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SIZE-1:0]  load_data,
  input  logic             ready,
  input  logic             cnt_clr,
  output logic             valid,
  output logic [SIZE-1:0]  data,
  output logic             free,
  output logic [CNT_W-1:0] cnt
);

  logic drain;

  assign drain = valid && ready;
  // Empty, or full and being emptied this cycle, so a new word may land.
  assign free  = !valid || ready;

  // Slot occupancy and data: load wins over drain so back-to-back words leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // Delivered-word counter: clear overrides increment, increment stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (drain && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer with unicast and broadcast routing.
module demux1to4_stream
  import demux1to4_stream_pkg::*;
#(
  parameter int unsigned SIZE  = DATA_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_bcast,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [SIZE-1:0]  out_data0,
  output logic [SIZE-1:0]  out_data1,
  output logic [SIZE-1:0]  out_data2,
  output logic [SIZE-1:0]  out_data3,
  output logic [CNT_W-1:0] xfer_cnt0,
  output logic [CNT_W-1:0] xfer_cnt1,
  output logic [CNT_W-1:0] xfer_cnt2,
  output logic [CNT_W-1:0] xfer_cnt3,
  input  logic             cnt_clr
);

  logic [3:0]       slot_free;
  logic [3:0]       sel_mask;
  logic [3:0]       load;
  logic             in_fire;
  logic [SIZE-1:0]  slot_data [4];
  logic [CNT_W-1:0] slot_cnt  [4];

  // Destination mask and readiness: broadcast needs every slot free, never a partial delivery.
  always_comb begin
    sel_mask = ch_onehot(ch_sel_e'(in_sel));
    if (in_bcast) begin
      in_ready = &slot_free;
    end else begin
      in_ready = |(slot_free & sel_mask);
    end
    in_fire = in_valid && in_ready;
    load    = '0;
    if (in_fire) begin
      load = in_bcast ? 4'b1111 : sel_mask;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    demux_slot #(
      .SIZE  (SIZE),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[gi]),
      .load_data (in_data),
      .ready     (out_ready[gi]),
      .cnt_clr   (cnt_clr),
      .valid     (out_valid[gi]),
      .data      (slot_data[gi]),
      .free      (slot_free[gi]),
      .cnt       (slot_cnt[gi])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];
  assign xfer_cnt0 = slot_cnt[0];
  assign xfer_cnt1 = slot_cnt[1];
  assign xfer_cnt2 = slot_cnt[2];
  assign xfer_cnt3 = slot_cnt[3];

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed bench for demux1to4_stream (16-bit data, 4-bit counters).
module tb_demux1to4_stream;

  localparam int unsigned SIZE  = 16;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  in_data;
  logic [1:0]       in_sel;
  logic             in_bcast;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [SIZE-1:0]  out_data0, out_data1, out_data2, out_data3;
  logic [CNT_W-1:0] xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3;
  logic             cnt_clr;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  demux1to4_stream #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .xfer_cnt0 (xfer_cnt0),
    .xfer_cnt1 (xfer_cnt1),
    .xfer_cnt2 (xfer_cnt2),
    .xfer_cnt3 (xfer_cnt3),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [SIZE-1:0] dat(input int unsigned i);
    case (i)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] cnt(input int unsigned i);
    case (i)
      0:       return xfer_cnt0;
      1:       return xfer_cnt1;
      2:       return xfer_cnt2;
      default: return xfer_cnt3;
    endcase
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    in_bcast  = 1'b0;
    out_ready = 4'b0000;
    cnt_clr   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    in_bcast  = 1'b0;
    out_ready = 4'b0000;
    cnt_clr   = 1'b0;
    step();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready_during got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL reset_out_valid got %b want 0000", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dat(i) !== 16'h0000 || cnt(i) !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_ch%0d got data %h cnt %0d want data 0000 cnt 0", i, dat(i), cnt(i));
      end
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready_after got %b want 1", in_ready);
    end
  endtask

  task automatic test_unicast();
    logic [SIZE-1:0] vals [4];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    do_reset();
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_sel   = 2'(k);
      in_data  = vals[k];
      step();
      vectors++;
      if (out_valid !== (4'b0001 << k) || dat(k) !== vals[k]) begin
        miscompares++;
        $display("FAIL uni_ch%0d got valid %b data %h want valid %b data %h",
                 k, out_valid, dat(k), 4'b0001 << k, vals[k]);
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL uni_idle_valid got %b want 0000", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (cnt(i) !== 4'd1) begin
        miscompares++; $display("FAIL uni_cnt%0d got %0d want 1", i, cnt(i));
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    out_ready = 4'b1011;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 16'hAAAA;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_ready_first got %b want 1", in_ready);
    end
    step();
    vectors++;
    if (out_valid[2] !== 1'b1 || out_data2 !== 16'hAAAA) begin
      miscompares++; $display("FAIL bp_first got valid %b data %h want 1 aaaa", out_valid[2], out_data2);
    end
    in_data = 16'hBBBB;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_ready_blocked got %b want 0", in_ready);
    end
    step();
    vectors++;
    if (out_valid[2] !== 1'b1 || out_data2 !== 16'hAAAA) begin
      miscompares++; $display("FAIL bp_hold got valid %b data %h want 1 aaaa", out_valid[2], out_data2);
    end
    in_sel  = 2'd0;
    in_data = 16'h0C0C;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_ready_ch0 got %b want 1", in_ready);
    end
    step();
    vectors++;
    if (out_valid !== 4'b0101 || out_data0 !== 16'h0C0C || out_data2 !== 16'hAAAA) begin
      miscompares++;
      $display("FAIL bp_ch0_pass got valid %b d0 %h d2 %h want 0101 0c0c aaaa", out_valid, out_data0, out_data2);
    end
    in_sel    = 2'd2;
    in_data   = 16'hBBBB;
    out_ready = 4'b1111;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_ready_release got %b want 1", in_ready);
    end
    step();
    vectors++;
    if (out_valid !== 4'b0100 || out_data2 !== 16'hBBBB || xfer_cnt2 !== 4'd1) begin
      miscompares++;
      $display("FAIL bp_second got valid %b d2 %h cnt2 %0d want 0100 bbbb 1", out_valid, out_data2, xfer_cnt2);
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 4'b0000 || xfer_cnt2 !== 4'd2 || xfer_cnt0 !== 4'd1) begin
      miscompares++;
      $display("FAIL bp_final got valid %b cnt2 %0d cnt0 %0d want 0000 2 1", out_valid, xfer_cnt2, xfer_cnt0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_sel   = 2'd1;
      in_data  = 16'h1000 + 16'(k);
      step();
      vectors++;
      if (out_valid[1] !== 1'b1 || out_data1 !== 16'h1000 + 16'(k)) begin
        miscompares++;
        $display("FAIL b2b_word%0d got valid %b data %h want 1 %h", k, out_valid[1], out_data1, 16'h1000 + 16'(k));
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid[1] !== 1'b0 || xfer_cnt1 !== 4'd10) begin
      miscompares++; $display("FAIL b2b_cnt got valid %b cnt1 %0d want 0 10", out_valid[1], xfer_cnt1);
    end
  endtask

  task automatic test_broadcast();
    do_reset();
    out_ready = 4'b0111;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    in_data   = 16'h3333;
    step();
    vectors++;
    if (out_valid !== 4'b1000) begin
      miscompares++; $display("FAIL bc_setup got %b want 1000", out_valid);
    end
    in_sel   = 2'd0;
    in_bcast = 1'b1;
    in_data  = 16'h5A5A;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL bc_ready_blocked got %b want 0", in_ready);
    end
    step();
    vectors++;
    if (out_valid !== 4'b1000 || out_data3 !== 16'h3333 || out_data0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL bc_no_partial got valid %b d3 %h d0 %h want 1000 3333 0000", out_valid, out_data3, out_data0);
    end
    out_ready = 4'b1111;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bc_ready_release got %b want 1", in_ready);
    end
    step();
    vectors++;
    if (out_valid !== 4'b1111) begin
      miscompares++; $display("FAIL bc_all_valid got %b want 1111", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dat(i) !== 16'h5A5A) begin
        miscompares++; $display("FAIL bc_data%0d got %h want 5a5a", i, dat(i));
      end
    end
    in_valid = 1'b0;
    in_bcast = 1'b0;
    step();
    vectors++;
    if (out_valid !== 4'b0000 || xfer_cnt3 !== 4'd2 || xfer_cnt0 !== 4'd1) begin
      miscompares++;
      $display("FAIL bc_counts got valid %b cnt3 %0d cnt0 %0d want 0000 2 1", out_valid, xfer_cnt3, xfer_cnt0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_sel   = 2'd0;
      in_data  = 16'h00E0 + 16'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (xfer_cnt0 !== 4'd15) begin
      miscompares++; $display("FAIL sat_cnt got %0d want 15", xfer_cnt0);
    end
    in_valid = 1'b1;
    in_data  = 16'hCAFE;
    step();
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    step();
    vectors++;
    if (xfer_cnt0 !== 4'd0 || out_valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_over_inc got cnt0 %0d valid %b want 0 0", xfer_cnt0, out_valid[0]);
    end
    cnt_clr  = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    step();
    in_valid = 1'b0;
    step();
    vectors++;
    if (xfer_cnt0 !== 4'd1) begin
      miscompares++; $display("FAIL clr_recount got %0d want 1", xfer_cnt0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 16'h0101;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_bcast  = 1'b1;
    in_data   = 16'h7777;
    step();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    vectors++;
    if (out_valid !== 4'b1111 || xfer_cnt0 !== 4'd1) begin
      miscompares++; $display("FAIL ar_setup got valid %b cnt0 %0d want 1111 1", out_valid, xfer_cnt0);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 4'b0000 || xfer_cnt0 !== 4'd0 || out_data0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL ar_immediate got valid %b cnt0 %0d d0 %h want 0000 0 0000", out_valid, xfer_cnt0, out_data0);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 16'h1234;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 4'b0100 || out_data2 !== 16'h1234) begin
      miscompares++;
      $display("FAIL ar_first_word got valid %b d2 %h want 0100 1234", out_valid, out_data2);
    end
    step();
    vectors++;
    if (xfer_cnt2 !== 4'd1 || xfer_cnt3 !== 4'd0) begin
      miscompares++;
      $display("FAIL ar_counts got cnt2 %0d cnt3 %0d want 1 0", xfer_cnt2, xfer_cnt3);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_back_pressure();
    test_back_to_back();
    test_broadcast();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
